umi_endpoint_arbiter: RTL and testbench
=======================================

Name: umi_endpoint_arbiter

Overview:
- Shares one UMI simple endpoint among N UMI device-side requesters.
- Round-robin arbitration with grant lock while the endpoint stalls.
- Records the owner of every accepted read in an in-order tag FIFO and routes each endpoint response back to that owner.
- Sits between N host/router ports and a single endpoint's udev_req/udev_resp channels.

Parameters:
N, 4, number of requesters (2..16)
DEPTH, 4, outstanding-read tag FIFO depth (power of 2, >=2)
CW, 32, UMI command width
AW, 64, UMI address width
DW, 256, UMI data width

Ports:
clk  input  1  clock
nreset  input  1  async active-low reset
req_valid  input  N  per-requester request valid
req_cmd  input  N*CW  packed commands, requester i at [i*CW +: CW]
req_dstaddr  input  N*AW  packed destination addresses
req_srcaddr  input  N*AW  packed source addresses
req_data  input  N*DW  packed write data
req_ready  output  N  per-requester ready
ep_req_valid  output  1  request valid to endpoint
ep_req_cmd  output  CW  muxed command
ep_req_dstaddr  output  AW  muxed dstaddr
ep_req_srcaddr  output  AW  muxed srcaddr
ep_req_data  output  DW  muxed data
ep_req_ready  input  1  endpoint ready
ep_resp_valid  input  1  endpoint response valid
ep_resp_cmd  input  CW  response command
ep_resp_dstaddr  input  AW  response dstaddr
ep_resp_srcaddr  input  AW  response srcaddr
ep_resp_data  input  DW  response data
ep_resp_ready  output  1  ready to endpoint
resp_valid  output  N  per-requester response valid (one-hot or zero)
resp_cmd  output  CW  response command, broadcast to all requesters
resp_dstaddr  output  AW  response dstaddr, broadcast
resp_srcaddr  output  AW  response srcaddr, broadcast
resp_data  output  DW  response data, broadcast
resp_ready  input  N  per-requester response ready
err_orphan  output  1  sticky: response arrived with tag FIFO empty

Behaviour:
- Clock/reset: single clock clk; nreset asynchronous, active-low. On reset: rr pointer=0, lock=0, FIFO empty (count=0), err_orphan=0. All outputs derived from these are therefore ep_req_valid=0, req_ready=0, resp_valid=0, ep_resp_ready=0.
- Eligibility: requester i is eligible if req_valid[i] is set, and, if its command is a read (umi_write classifies write=0), the tag FIFO is not full. Writes are always eligible.
- Arbitration is combinational (0-cycle). The grant is the first eligible requester scanning pnt, pnt+1, ... mod N.
  - ep_req_* = muxed fields of the granted requester.
  - ep_req_valid = any eligible.
  - req_ready[g] = ep_req_ready; all other req_ready bits are 0.
- Grant lock: if ep_req_valid & !ep_req_ready, register lock=1 and hold the grant index. The next cycle forces the same grant regardless of the pointer, per the UMI rule that valid stays stable until ready. Lock clears on handshake.
- Pointer: on handshake (ep_req_valid & ep_req_ready), pnt <= (g+1) mod N. Otherwise pnt holds.
- Tag FIFO:
  - Push g on a handshake whose command is a read.
  - Pop on response handshake (ep_resp_valid & ep_resp_ready).
  - Simultaneous push and pop leaves count unchanged.
  - Full means count==DEPTH. A full FIFO blocks only reads; writes still flow.
  - Pointers wrap mod DEPTH.
- Response routing: owner = FIFO head.
  - resp_valid[owner] = ep_resp_valid & !empty.
  - ep_resp_ready = resp_ready[owner] when not empty.
  - resp_* fields pass through combinationally.
- Orphan response: ep_resp_valid while empty sets err_orphan (sticky until reset). In that case ep_resp_ready=1 (the response is dropped) and no resp_valid bit is set.
- Responses are strictly in order; the endpoint returns read data in request order.
- Reset mid-operation discards all pending tags and the lock. Responses arriving after reset are treated as orphans.

Decomposition:
- Shared package umi_arb_pkg:
  - CLOG2-based width constant for the tag (IDW=$clog2(N)).
  - Read/write classification reuses the existing umi_write module, one instance per requester.
- One natural sub-module: umi_arb_tagfifo (DEPTH x IDW synchronous FIFO with full/empty/count, async active-low reset).

Test Plan:
- Reset: N=4, hold nreset=0 with all req_valid=1 -> ep_req_valid=0, resp_valid=0, err_orphan=0. After release, first grant is requester 0.
- Round-robin: all 4 requesters issue writes continuously with ep_req_ready=1 -> grant sequence 0,1,2,3,0,1 on consecutive cycles.
- Lock under stall: requester 2 wins, ep_req_ready=0 for 3 cycles while requester 0 also asserts -> grant stays 2 with ep_req_* stable. Handshake occurs on cycle 4, and the next grant is 3 if valid, else 0.
- Routing: requester 1 reads, then requester 3 reads; endpoint returns two responses -> resp_valid=0b0010 then 0b1000. With resp_ready[3]=0 for 2 cycles, ep_resp_ready=0 for those cycles.
- Full FIFO: DEPTH=4, issue 4 reads with no responses, then a 5th read and a write -> the read is stalled (req_ready=0) and the write is accepted. After one response pops, the read is accepted.
- Orphan: ep_resp_valid=1 with FIFO empty -> ep_resp_ready=1, resp_valid=0, err_orphan=1 and remaining 1 until nreset.

Source files
------------

// File: rtl/umi_arb_pkg.sv
// Shared types and helpers for the UMI endpoint arbiter.
package umi_arb_pkg;

    // UMI request opcode that expects read data back
    localparam logic [4:0] UMI_REQ_READ = 5'h01;

    // Grant state: free to re-arbitrate, or locked on a stalled request
    typedef enum logic {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Width of a requester index (tag) for n requesters
    function automatic int arbTagWidth(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/umi_arb_tagfifo.sv
// In-order FIFO of requester tags for outstanding reads.
module umi_arb_tagfifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [PW:0]   r_count;
    logic          w_doPush;
    logic          w_doPop;

    assign w_doPush = i_push & ~o_full;
    assign w_doPop  = i_pop & ~o_empty;
    assign o_full   = (r_count == CNT_FULL);
    assign o_empty  = (r_count == '0);
    assign o_dout   = r_mem[r_rd];

    // Storage needs no reset; only the pointers define what is valid
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wr] <= i_din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wr <= r_wr + 1'b1;
            if (w_doPop)  r_rd <= r_rd + 1'b1;
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/umi_write.sv
// Classifies a UMI request opcode as write-like (no read data returned) or read.
module umi_write
    import umi_arb_pkg::*;
(
    input  logic [4:0] i_opcode,
    output logic       o_write
);

    assign o_write = (i_opcode != UMI_REQ_READ);

endmodule

// File: rtl/umi_endpoint_arbiter.sv
// Round-robin arbiter sharing one UMI endpoint among N requesters, with
// in-order response routing back to the owner of each read.
module umi_endpoint_arbiter
    import umi_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = 4,
    parameter int CW    = 32,
    parameter int AW    = 64,
    parameter int DW    = 256
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic [N-1:0]    req_valid,
    input  logic [N*CW-1:0] req_cmd,
    input  logic [N*AW-1:0] req_dstaddr,
    input  logic [N*AW-1:0] req_srcaddr,
    input  logic [N*DW-1:0] req_data,
    output logic [N-1:0]    req_ready,
    output logic            ep_req_valid,
    output logic [CW-1:0]   ep_req_cmd,
    output logic [AW-1:0]   ep_req_dstaddr,
    output logic [AW-1:0]   ep_req_srcaddr,
    output logic [DW-1:0]   ep_req_data,
    input  logic            ep_req_ready,
    input  logic            ep_resp_valid,
    input  logic [CW-1:0]   ep_resp_cmd,
    input  logic [AW-1:0]   ep_resp_dstaddr,
    input  logic [AW-1:0]   ep_resp_srcaddr,
    input  logic [DW-1:0]   ep_resp_data,
    output logic            ep_resp_ready,
    output logic [N-1:0]    resp_valid,
    output logic [CW-1:0]   resp_cmd,
    output logic [AW-1:0]   resp_dstaddr,
    output logic [AW-1:0]   resp_srcaddr,
    output logic [DW-1:0]   resp_data,
    input  logic [N-1:0]    resp_ready,
    output logic            err_orphan
);

    localparam int IDW = arbTagWidth(N);

    arb_state_e     r_state;
    logic [IDW-1:0] r_lockIdx;
    logic [IDW-1:0] r_pnt;
    logic           r_orphan;

    logic [N-1:0]   w_isWrite;
    logic [N-1:0]   w_elig;
    logic [IDW-1:0] w_scanIdx;
    logic [IDW-1:0] w_grant;
    logic [IDW-1:0] w_head;
    logic           w_epValid;
    logic           w_reqHs;
    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;

    for (genvar gi = 0; gi < N; gi++) begin : g_cls
        umi_write u_write (
            .i_opcode (req_cmd[gi*CW +: 5]),
            .o_write  (w_isWrite[gi])
        );
    end

    // A full tag FIFO holds back reads only; writes never need a tag
    assign w_elig = req_valid & (w_isWrite | {N{~w_full}});

    // Pick the first eligible requester at or after the pointer, wrapping at N
    always_comb begin
        logic [IDW-1:0] idx;
        w_scanIdx = r_pnt;
        for (int k = N - 1; k >= 0; k--) begin
            idx = IDW'((int'(r_pnt) + k) % N);
            if (w_elig[idx]) begin
                w_scanIdx = idx;
            end
        end
    end

    // A stalled request keeps its grant; outputs are forced idle while in reset
    assign w_grant   = (r_state == ARB_LOCKED) ? r_lockIdx : w_scanIdx;
    assign w_epValid = nreset & ((r_state == ARB_LOCKED) ? w_elig[r_lockIdx] : (|w_elig));
    assign w_reqHs   = w_epValid & ep_req_ready;
    assign w_push    = w_reqHs & ~w_isWrite[w_grant];
    assign ep_req_valid = w_epValid;

    // Steer the granted requester's fields to the endpoint and return its ready
    always_comb begin
        ep_req_cmd     = req_cmd[CW-1:0];
        ep_req_dstaddr = req_dstaddr[AW-1:0];
        ep_req_srcaddr = req_srcaddr[AW-1:0];
        ep_req_data    = req_data[DW-1:0];
        req_ready      = '0;
        for (int k = 0; k < N; k++) begin
            if (w_grant == IDW'(k)) begin
                ep_req_cmd     = req_cmd[k*CW +: CW];
                ep_req_dstaddr = req_dstaddr[k*AW +: AW];
                ep_req_srcaddr = req_srcaddr[k*AW +: AW];
                ep_req_data    = req_data[k*DW +: DW];
            end
        end
        if (w_reqHs) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    // Orphan responses (no tag outstanding) are accepted and dropped
    assign ep_resp_ready = nreset & (w_empty ? ep_resp_valid : resp_ready[w_head]);
    assign w_pop         = ep_resp_valid & ep_resp_ready & ~w_empty;
    assign resp_cmd      = ep_resp_cmd;
    assign resp_dstaddr  = ep_resp_dstaddr;
    assign resp_srcaddr  = ep_resp_srcaddr;
    assign resp_data     = ep_resp_data;
    assign err_orphan    = r_orphan;

    // Only the owner at the FIFO head sees the response
    always_comb begin
        resp_valid = '0;
        if (nreset && ep_resp_valid && !w_empty) begin
            resp_valid[w_head] = 1'b1;
        end
    end

    // Lock the grant during a stall and advance the pointer past each winner
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state   <= ARB_FREE;
            r_lockIdx <= '0;
            r_pnt     <= '0;
        end else begin
            if (w_epValid && !ep_req_ready) begin
                r_state   <= ARB_LOCKED;
                r_lockIdx <= w_grant;
            end else begin
                r_state <= ARB_FREE;
            end
            if (w_reqHs) begin
                r_pnt <= IDW'((int'(w_grant) + 1) % N);
            end
        end
    end

    // Sticky flag for responses that arrive with no outstanding read
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_orphan <= 1'b0;
        end else if (ep_resp_valid && w_empty) begin
            r_orphan <= 1'b1;
        end
    end

    umi_arb_tagfifo #(
        .DEPTH (DEPTH),
        .W     (IDW)
    ) u_tagfifo (
        .clk     (clk),
        .nreset  (nreset),
        .i_push  (w_push),
        .i_din   (w_grant),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_umi_endpoint_arbiter.sv
// Randomized bench for umi_endpoint_arbiter with a behavioural reference model.
module tb_umi_endpoint_arbiter;

    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 32;
    localparam int AW    = 64;
    localparam int DW    = 256;

    logic            clk = 1'b0;
    logic            nreset;
    logic [N-1:0]    req_valid;
    logic [N*CW-1:0] req_cmd;
    logic [N*AW-1:0] req_dstaddr;
    logic [N*AW-1:0] req_srcaddr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            ep_req_valid;
    logic [CW-1:0]   ep_req_cmd;
    logic [AW-1:0]   ep_req_dstaddr;
    logic [AW-1:0]   ep_req_srcaddr;
    logic [DW-1:0]   ep_req_data;
    logic            ep_req_ready;
    logic            ep_resp_valid;
    logic [CW-1:0]   ep_resp_cmd;
    logic [AW-1:0]   ep_resp_dstaddr;
    logic [AW-1:0]   ep_resp_srcaddr;
    logic [DW-1:0]   ep_resp_data;
    logic            ep_resp_ready;
    logic [N-1:0]    resp_valid;
    logic [CW-1:0]   resp_cmd;
    logic [AW-1:0]   resp_dstaddr;
    logic [AW-1:0]   resp_srcaddr;
    logic [DW-1:0]   resp_data;
    logic [N-1:0]    resp_ready;
    logic            err_orphan;

    umi_endpoint_arbiter #(.N(N), .DEPTH(DEPTH), .CW(CW), .AW(AW), .DW(DW)) dut (
        .clk(clk), .nreset(nreset),
        .req_valid(req_valid), .req_cmd(req_cmd), .req_dstaddr(req_dstaddr),
        .req_srcaddr(req_srcaddr), .req_data(req_data), .req_ready(req_ready),
        .ep_req_valid(ep_req_valid), .ep_req_cmd(ep_req_cmd), .ep_req_dstaddr(ep_req_dstaddr),
        .ep_req_srcaddr(ep_req_srcaddr), .ep_req_data(ep_req_data), .ep_req_ready(ep_req_ready),
        .ep_resp_valid(ep_resp_valid), .ep_resp_cmd(ep_resp_cmd), .ep_resp_dstaddr(ep_resp_dstaddr),
        .ep_resp_srcaddr(ep_resp_srcaddr), .ep_resp_data(ep_resp_data), .ep_resp_ready(ep_resp_ready),
        .resp_valid(resp_valid), .resp_cmd(resp_cmd), .resp_dstaddr(resp_dstaddr),
        .resp_srcaddr(resp_srcaddr), .resp_data(resp_data), .resp_ready(resp_ready),
        .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;

    // Stimulus knobs (percent probabilities)
    int pReq, pRead, pEpReady, pResp, pRespReady;
    bit orphanMode;

    // Reference model: owners of outstanding reads in order, rotation point,
    // the requester whose request is stuck waiting, and the sticky orphan flag
    int ownerQ[$];
    int mNext;
    bit mStuck;
    int mStuckIdx;
    bit mOrphan;
    int epPending;

    // Bookkeeping applied at the start of the next cycle
    logic [N-1:0] hsMask;
    bit respDone;
    logic [N-1:0] lastReqReady;
    logic [CW-1:0] lastCmd;
    logic lastOrphan;

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit isWriteCmd(input logic [CW-1:0] c);
        return c[4:0] != 5'h01;
    endfunction

    task automatic newReq(input int i);
        logic [CW-1:0] c;
        c = $urandom;
        if ($urandom_range(99) < pRead) c[4:0] = 5'h01;
        else c[4:0] = ($urandom_range(1) == 0) ? 5'h03 : 5'h05;
        req_cmd[i*CW +: CW]     = c;
        req_dstaddr[i*AW +: AW] = {$urandom, $urandom};
        req_srcaddr[i*AW +: AW] = {$urandom, $urandom};
        for (int j = 0; j < DW/32; j++) req_data[i*DW + j*32 +: 32] = $urandom;
        req_valid[i] = 1'b1;
    endtask

    task automatic newResp();
        ep_resp_valid   = 1'b1;
        ep_resp_cmd     = $urandom;
        ep_resp_dstaddr = {$urandom, $urandom};
        ep_resp_srcaddr = {$urandom, $urandom};
        for (int j = 0; j < DW/32; j++) ep_resp_data[j*32 +: 32] = $urandom;
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model
    task automatic applyStimulus();
        logic [N-1:0] elig;
        logic [N-1:0] expReqReady;
        logic [N-1:0] expRespValid;
        logic expEpRespReady;
        bit expValid;
        bit reqHs;
        int g;

        req_valid = req_valid & ~hsMask;
        if (respDone) ep_resp_valid = 1'b0;
        hsMask = '0;
        respDone = 1'b0;
        for (int i = 0; i < N; i++)
            if (!req_valid[i] && $urandom_range(99) < pReq) newReq(i);
        ep_req_ready = ($urandom_range(99) < pEpReady);
        if (!ep_resp_valid && (epPending > 0 || orphanMode) && $urandom_range(99) < pResp) newResp();
        for (int i = 0; i < N; i++) resp_ready[i] = ($urandom_range(99) < pRespReady);
        #1;

        for (int i = 0; i < N; i++)
            elig[i] = req_valid[i] && (isWriteCmd(req_cmd[i*CW +: CW]) || ownerQ.size() < DEPTH);
        expValid = 1'b0;
        g = mNext;
        if (mStuck) begin
            g = mStuckIdx;
            expValid = elig[g];
        end else begin
            for (int k = 0; k < N; k++)
                if (!expValid && elig[(mNext + k) % N]) begin
                    g = (mNext + k) % N;
                    expValid = 1'b1;
                end
        end
        expReqReady = '0;
        if (expValid && ep_req_ready) expReqReady[g] = 1'b1;

        checkOutput("ep_req_valid", ep_req_valid, expValid);
        checkOutput("req_ready", req_ready, expReqReady);
        if (expValid) begin
            checkOutput("ep_req_cmd", ep_req_cmd, req_cmd[g*CW +: CW]);
            checkOutput("ep_req_dstaddr", ep_req_dstaddr, req_dstaddr[g*AW +: AW]);
            checkOutput("ep_req_srcaddr", ep_req_srcaddr, req_srcaddr[g*AW +: AW]);
            checkOutput("ep_req_data", ep_req_data, req_data[g*DW +: DW]);
        end

        expRespValid = '0;
        if (ownerQ.size() == 0) begin
            expEpRespReady = ep_resp_valid;
        end else begin
            if (ep_resp_valid) expRespValid[ownerQ[0]] = 1'b1;
            expEpRespReady = resp_ready[ownerQ[0]];
        end
        checkOutput("resp_valid", resp_valid, expRespValid);
        checkOutput("ep_resp_ready", ep_resp_ready, expEpRespReady);
        checkOutput("err_orphan", err_orphan, mOrphan);
        if (ep_resp_valid) begin
            checkOutput("resp_cmd", resp_cmd, ep_resp_cmd);
            checkOutput("resp_data", resp_data, ep_resp_data);
        end
        lastReqReady = req_ready;
        lastCmd = ep_req_cmd;
        lastOrphan = err_orphan;

        if (ep_resp_valid) begin
            if (ownerQ.size() == 0) begin
                mOrphan = 1'b1;
                respDone = 1'b1;
            end else if (resp_ready[ownerQ[0]]) begin
                void'(ownerQ.pop_front());
                if (epPending > 0) epPending--;
                respDone = 1'b1;
            end
        end
        reqHs = expValid && ep_req_ready;
        if (reqHs) begin
            if (!isWriteCmd(req_cmd[g*CW +: CW])) begin
                ownerQ.push_back(g);
                epPending++;
            end
            mNext = (g + 1) % N;
            hsMask[g] = 1'b1;
        end
        mStuck = expValid && !ep_req_ready;
        mStuckIdx = g;

        @(posedge clk);
        #2;
    endtask

    // Hold reset with every requester asserting, then release it
    task automatic applyReset();
        nreset = 1'b0;
        req_valid = req_valid & ~hsMask;
        hsMask = '0;
        respDone = 1'b0;
        ep_resp_valid = 1'b0;
        for (int i = 0; i < N; i++) if (!req_valid[i]) newReq(i);
        ep_req_ready = 1'b1;
        resp_ready = '1;
        ownerQ.delete();
        mNext = 0;
        mStuck = 1'b0;
        mOrphan = 1'b0;
        epPending = 0;
        #1;
        checkOutput("rst ep_req_valid", ep_req_valid, 1'b0);
        checkOutput("rst req_ready", req_ready, '0);
        checkOutput("rst resp_valid", resp_valid, '0);
        checkOutput("rst ep_resp_ready", ep_resp_ready, 1'b0);
        checkOutput("rst err_orphan", err_orphan, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst hold ep_req_valid", ep_req_valid, 1'b0);
        nreset = 1'b1;
    endtask

    initial begin
        int rrSeq[6];
        rrSeq = '{0, 1, 2, 3, 0, 1};
        nreset = 1'b0;
        req_valid = '0; req_cmd = '0; req_dstaddr = '0; req_srcaddr = '0; req_data = '0;
        ep_req_ready = 1'b0; ep_resp_valid = 1'b0; ep_resp_cmd = '0;
        ep_resp_dstaddr = '0; ep_resp_srcaddr = '0; ep_resp_data = '0; resp_ready = '0;
        hsMask = '0; respDone = 1'b0; orphanMode = 1'b0;
        pReq = 100; pRead = 0; pEpReady = 100; pResp = 0; pRespReady = 100;

        @(posedge clk);
        #2;
        applyReset();

        // Continuous writes rotate through every requester
        for (int k = 0; k < 6; k++) begin
            applyStimulus();
            checkOutput($sformatf("rr grant %0d", k), lastReqReady, 4'b0001 << rrSeq[k]);
        end

        // Requester 2 holds the grant while the endpoint stalls
        pEpReady = 0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus();
            checkOutput("lock req_ready", lastReqReady, 4'b0000);
            checkOutput("lock ep_req_cmd", lastCmd, req_cmd[2*CW +: CW]);
        end
        pEpReady = 100;
        applyStimulus();
        checkOutput("lock release", lastReqReady, 4'b0100);
        applyStimulus();
        checkOutput("after lock", lastReqReady, 4'b1000);

        // Fill the tag FIFO with reads, then mix in writes while it is full
        pReq = 60; pRead = 100; pEpReady = 80; pResp = 0;
        repeat (30) applyStimulus();
        checkOutput("fifo full depth", ownerQ.size(), DEPTH);
        pRead = 50;
        repeat (20) applyStimulus();

        // Free-running mixed traffic
        pResp = 40; pRespReady = 70;
        repeat (600) applyStimulus();

        // Reset in the middle of traffic drops all outstanding tags
        applyReset();
        pEpReady = 50; pResp = 50; pRespReady = 60;
        repeat (600) applyStimulus();

        // Drain, then present responses with nothing outstanding
        pReq = 0; pResp = 100; pRespReady = 100; pEpReady = 100;
        repeat (60) applyStimulus();
        applyReset();
        req_valid = '0;
        pResp = 100;
        orphanMode = 1'b1;
        repeat (4) applyStimulus();
        orphanMode = 1'b0;
        repeat (4) applyStimulus();
        checkOutput("orphan sticky", lastOrphan, 1'b1);
        applyReset();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
